pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into the data registers on reset and flush.
REQ-003 SHALL have parameter SKID, default 1, mode select:
- 1 = two-entry skid buffer with registered in_ready.
- 0 = single-entry stage with combinational in_ready.
REQ-004 clk  input  1  clock; all state updates on posedge clk only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous discard of all held beats.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts a beat this cycle.
REQ-012 out_data  output  WIDTH  downstream payload, driven directly from the main data register.
REQ-013 occ  output  2  beats held: 0, 1 or 2; 2 only when SKID=1.

Function
REQ-014 Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 Beats SHALL leave in acceptance order, none duplicated or dropped except by flush or rst.
REQ-016 Latency SHALL be exactly 1 cycle: a beat accepted at edge N is on out_data with out_valid=1 after edge N.
REQ-017 SKID=1 states: EMPTY (occ=0), ONE (occ=1), TWO (occ=2); main and skid WIDTH-bit registers.
REQ-018 SKID=1 in_ready SHALL be a registered function of state only: 1 in EMPTY/ONE, 0 in TWO.
REQ-019 SKID=1 transitions:
- EMPTY + in_fire -> ONE, main<=in_data.
- ONE + in_fire, no out_fire -> TWO, skid<=in_data.
- ONE + in_fire + out_fire -> ONE, main<=in_data.
- ONE + out_fire only -> EMPTY.
- TWO + out_fire -> ONE, main<=skid.
- All other cases SHALL hold state.
REQ-020 SKID=0 states: EMPTY, FULL; in_ready = ~out_valid | out_ready (combinational).
REQ-021 SKID=0: in_fire loads main; state is FULL after any edge with in_fire, EMPTY after out_fire without in_fire.
REQ-022 out_valid SHALL be 1 exactly when state is not EMPTY.
REQ-023 On a transition to EMPTY, main SHALL retain its last value; out_data is don't-care while out_valid=0.
REQ-024 out_data SHALL not change while out_valid=1 and out_ready=0 (stall stability).
REQ-025 flush=1 at an edge SHALL force EMPTY, occ=0, main=skid=RESET_VALUE, regardless of in_fire/out_fire that cycle.
REQ-026 A beat with in_fire in the same cycle as flush SHALL be discarded.
REQ-027 Priority SHALL be rst > flush > normal transfer.
REQ-028 occ SHALL equal the encoded state in every cycle.

Reset
REQ-029 rst=1 at an edge SHALL force EMPTY: out_valid=0, occ=0, main=skid=RESET_VALUE, out_data=RESET_VALUE.
REQ-030 With rst=1, in_ready SHALL be 1 from the next edge when SKID=1, and follow REQ-020 when SKID=0.
REQ-031 rst asserted mid-operation, including in state TWO, SHALL discard all held beats with no output beat produced.
REQ-032 A beat presented during rst=1 SHALL not be accepted.

Verification
REQ-033 SKID=1, out_ready=1 continuously, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next four cycles, occ=1 throughout, in_ready=1.
REQ-034 SKID=1, hold out_ready=0, send 0xA then 0xB -> occ=2, in_ready=0, out_data=0xA stable; raise out_ready for 2 cycles -> outputs 0xA then 0xB, occ returns to 0.
REQ-035 SKID=1 in state TWO, assert flush with in_valid=1 and in_data=0xC -> next cycle out_valid=0, occ=0, in_ready=1, out_data=RESET_VALUE; 0xC never appears at the output.
REQ-036 SKID=0, out_valid=1 and out_ready=0 -> in_ready=0; out_ready=1 with in_valid=1 and in_data=0x5 in the same cycle -> next cycle out_data=0x5, occ=1.
REQ-037 WIDTH=8, RESET_VALUE=0x5A, assert rst while in state ONE -> out_valid=0, out_data=0x5A; a beat offered during rst is not output.
REQ-038 Randomised in_valid/out_ready over 10k cycles in both SKID modes -> output sequence equals input sequence, and out_data never changes during a stall.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake on both sides.
// SKID=1: two-entry skid buffer (main + skid registers), registered in_ready.
// SKID=0: single-entry stage, in_ready derived combinationally from out_ready.
// out_data always comes straight from the main data register.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      SKID        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    if (SKID != 0) begin : g_skid

        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            TWO   = 2'd2
        } skid_state_t;

        skid_state_t      st_q, st_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             ready_q;
        logic             in_fire;
        logic             out_fire;

        assign in_fire  = in_valid & ready_q;
        assign out_fire = (st_q != EMPTY) & out_ready;

        // Next-state and data-register update for the skid buffer; flush overrides any transfer.
        always_comb begin
            st_d   = st_q;
            main_d = main_q;
            skid_d = skid_q;
            case (st_q)
                EMPTY: begin
                    if (in_fire) begin
                        st_d   = ONE;
                        main_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        st_d   = TWO;
                        skid_d = in_data;
                    end else if (out_fire) begin
                        st_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        st_d   = ONE;
                        main_d = skid_q;
                    end
                end
                default: begin
                    st_d = EMPTY;
                end
            endcase
            if (flush) begin
                st_d   = EMPTY;
                main_d = RESET_VALUE;
                skid_d = RESET_VALUE;
            end
        end

        // State, data and ready registers; ready is computed from the next state so it
        // stays a pure flop output while still reflecting the state held after the edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q    <= EMPTY;
                main_q  <= RESET_VALUE;
                skid_q  <= RESET_VALUE;
                ready_q <= 1'b1;
            end else begin
                st_q    <= st_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= (st_d != TWO);
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = (st_q != EMPTY);
        assign out_data  = main_q;
        assign occ       = st_q;

    end else begin : g_single

        typedef enum logic {
            EMPTY = 1'b0,
            FULL  = 1'b1
        } single_state_t;

        single_state_t    st_q, st_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic             valid;
        logic             ready;
        logic             in_fire;
        logic             out_fire;

        assign valid    = (st_q == FULL);
        assign ready    = ~valid | out_ready;
        assign in_fire  = in_valid & ready;
        assign out_fire = valid & out_ready;

        // Next-state for the single-entry stage; a new beat always wins over a drain.
        always_comb begin
            st_d   = st_q;
            main_d = main_q;
            if (in_fire) begin
                st_d   = FULL;
                main_d = in_data;
            end else if (out_fire) begin
                st_d = EMPTY;
            end
            if (flush) begin
                st_d   = EMPTY;
                main_d = RESET_VALUE;
            end
        end

        // State and main data register.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= EMPTY;
                main_q <= RESET_VALUE;
            end else begin
                st_q   <= st_d;
                main_q <= main_d;
            end
        end

        assign in_ready  = ready;
        assign out_valid = valid;
        assign out_data  = main_q;
        assign occ       = {1'b0, valid};

    end

endmodule
